// File: rtl/key_pkg.sv
// ---------------------------------------------------------------------------
// key_pkg
// Shared definitions for the multi-key press detector.
//   key_state_t  : per-channel state of the press classifier
//   DEFAULT_*    : default cycle counts for a 100 MHz system clock
//   cntWidth()   : width of a counter that must hold the largest cycle count
// The optional auto-repeat feature is enabled with the KEY_REPEAT_EN macro.
// ---------------------------------------------------------------------------
package key_pkg;

   typedef enum logic [2:0] {
      LOCKOUT,
      IDLE,
      DEB_PRESS,
      HELD,
      LONG_HELD,
      DEB_RELEASE
   } key_state_t;

   localparam int DEFAULT_NUM_KEYS     = 6;
   localparam int DEFAULT_DEBOUNCE_CYC = 200000;     // 2 ms
   localparam int DEFAULT_LONG_CYC     = 300000000;  // 3 s
   localparam int DEFAULT_REPEAT_CYC   = 25000000;   // 250 ms

   // Width large enough to count up to the largest of the three periods.
   function automatic int cntWidth(input int a, input int b, input int c);
      int m;
      m = a;
      if (b > m) m = b;
      if (c > m) m = c;
      return $clog2(m + 1);
   endfunction

endpackage

// File: rtl/key_channel.sv
// ---------------------------------------------------------------------------
// key_channel
// One key: 2-flop synchroniser, debounce, short/long press classification.
// The input is already polarity-normalised (1 = pressed).
// Ports:
//   clk       : system clock
//   reset     : asynchronous active-high reset
//   key_i     : raw (asynchronous) normalised key level
//   pressed_o : debounced level, 1 while the press is accepted
//   short_o   : 1-cycle pulse when a press is released before the long time
//   long_o    : 1-cycle pulse when the hold reaches the long time
//               (plus auto-repeat pulses when KEY_REPEAT_EN is defined)
// Macro KEY_REPEAT_EN: enables the repeat counter in LONG_HELD.
// ---------------------------------------------------------------------------
module key_channel
   import key_pkg::*;
#(
   parameter int DEBOUNCE_CYC = DEFAULT_DEBOUNCE_CYC,
   parameter int LONG_CYC     = DEFAULT_LONG_CYC,
   parameter int REPEAT_CYC   = DEFAULT_REPEAT_CYC
) (
   input  logic clk,
   input  logic reset,
   input  logic key_i,
   output logic pressed_o,
   output logic short_o,
   output logic long_o
);

   localparam int CNT_W = cntWidth(DEBOUNCE_CYC, LONG_CYC, REPEAT_CYC);
   localparam logic [CNT_W-1:0] DEB_LAST  = CNT_W'(DEBOUNCE_CYC - 1);
   localparam logic [CNT_W-1:0] LONG_LAST = CNT_W'(LONG_CYC - 1);
   localparam logic [CNT_W-1:0] CNT_ONE   = CNT_W'(1);

   logic             meta_q;
   logic             sync_q;
   key_state_t       state_q, state_d;
   logic [CNT_W-1:0] debCnt_q, debCnt_d;
   logic [CNT_W-1:0] holdCnt_q, holdCnt_d;
   logic             shortPending_q, shortPending_d;
   logic             short_q, short_d;
   logic             long_q, long_d;
`ifdef KEY_REPEAT_EN
   localparam logic [CNT_W-1:0] REP_LAST = CNT_W'(REPEAT_CYC - 1);
   logic [CNT_W-1:0] repCnt_q, repCnt_d;
`endif

   // Two-flop synchroniser; clears to "released" so a key held through
   // reset looks released for two cycles and is then caught by LOCKOUT.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         meta_q <= 1'b0;
         sync_q <= 1'b0;
      end else begin
         meta_q <= key_i;
         sync_q <= meta_q;
      end
   end

   // State, counters and registered pulse outputs. Reset drops any pulse
   // that was about to be issued.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q        <= LOCKOUT;
         debCnt_q       <= '0;
         holdCnt_q      <= '0;
         shortPending_q <= 1'b0;
         short_q        <= 1'b0;
         long_q         <= 1'b0;
`ifdef KEY_REPEAT_EN
         repCnt_q       <= '0;
`endif
      end else begin
         state_q        <= state_d;
         debCnt_q       <= debCnt_d;
         holdCnt_q      <= holdCnt_d;
         shortPending_q <= shortPending_d;
         short_q        <= short_d;
         long_q         <= long_d;
`ifdef KEY_REPEAT_EN
         repCnt_q       <= repCnt_d;
`endif
      end
   end

   // Next-state logic. A release is checked before the long-press count so
   // that a low sample always freezes the hold counter. shortPending
   // remembers whether the bounce in DEB_RELEASE came from HELD (short press
   // still possible) or from LONG_HELD.
   always_comb begin
      state_d        = state_q;
      debCnt_d       = debCnt_q;
      holdCnt_d      = holdCnt_q;
      shortPending_d = shortPending_q;
      short_d        = 1'b0;
      long_d         = 1'b0;
`ifdef KEY_REPEAT_EN
      repCnt_d       = repCnt_q;
`endif
      case (state_q)
         LOCKOUT: begin
            if (sync_q) begin
               debCnt_d = '0;
            end else if (debCnt_q == DEB_LAST) begin
               state_d  = IDLE;
               debCnt_d = '0;
            end else begin
               debCnt_d = debCnt_q + CNT_ONE;
            end
         end
         IDLE: begin
            if (sync_q) begin
               state_d  = DEB_PRESS;
               debCnt_d = '0;
            end
         end
         DEB_PRESS: begin
            if (!sync_q) begin
               state_d = IDLE;
            end else if (debCnt_q == DEB_LAST) begin
               state_d   = HELD;
               holdCnt_d = '0;
            end else begin
               debCnt_d = debCnt_q + CNT_ONE;
            end
         end
         HELD: begin
            if (!sync_q) begin
               state_d        = DEB_RELEASE;
               debCnt_d       = '0;
               shortPending_d = 1'b1;
            end else if (holdCnt_q == LONG_LAST) begin
               state_d = LONG_HELD;
               long_d  = 1'b1;
`ifdef KEY_REPEAT_EN
               repCnt_d = '0;
`endif
            end else begin
               holdCnt_d = holdCnt_q + CNT_ONE;
            end
         end
         LONG_HELD: begin
            if (!sync_q) begin
               state_d        = DEB_RELEASE;
               debCnt_d       = '0;
               shortPending_d = 1'b0;
`ifdef KEY_REPEAT_EN
               repCnt_d       = '0;
            end else if (repCnt_q == REP_LAST) begin
               long_d   = 1'b1;
               repCnt_d = '0;
            end else begin
               repCnt_d = repCnt_q + CNT_ONE;
`endif
            end
         end
         DEB_RELEASE: begin
            if (sync_q) begin
               state_d = shortPending_q ? HELD : LONG_HELD;
            end else if (debCnt_q == DEB_LAST) begin
               state_d        = IDLE;
               short_d        = shortPending_q;
               shortPending_d = 1'b0;
            end else begin
               debCnt_d = debCnt_q + CNT_ONE;
            end
         end
         default: begin
            state_d = LOCKOUT;
         end
      endcase
   end

   // The debounced level covers the release bounce too, so short dips while
   // held never reach the consumers.
   assign pressed_o = (state_q == HELD) || (state_q == LONG_HELD) ||
                      (state_q == DEB_RELEASE);
   assign short_o   = short_q;
   assign long_o    = long_q;

endmodule

// File: rtl/multi_key_press_detector.sv
// ---------------------------------------------------------------------------
// multi_key_press_detector
// NUM_KEYS independent key channels between the board pins and the control
// FSMs. Each channel debounces its pin and classifies short / long presses.
// Ports:
//   clk         : system clock
//   reset       : asynchronous active-high reset
//   key_in      : raw key pins, bit i = channel i
//   pressed     : debounced key levels
//   short_press : 1-cycle pulses, released before LONG_CYC
//   long_press  : 1-cycle pulses, hold reached LONG_CYC (plus repeats)
// Macro KEY_REPEAT_EN: auto-repeat long_press pulses every REPEAT_CYC cycles.
// ---------------------------------------------------------------------------
module multi_key_press_detector
   import key_pkg::*;
#(
   parameter int NUM_KEYS     = DEFAULT_NUM_KEYS,
   parameter int DEBOUNCE_CYC = DEFAULT_DEBOUNCE_CYC,
   parameter int LONG_CYC     = DEFAULT_LONG_CYC,
   parameter int REPEAT_CYC   = DEFAULT_REPEAT_CYC,
   parameter int ACTIVE_HIGH  = 1
) (
   input  logic                clk,
   input  logic                reset,
   input  logic [NUM_KEYS-1:0] key_in,
   output logic [NUM_KEYS-1:0] pressed,
   output logic [NUM_KEYS-1:0] short_press,
   output logic [NUM_KEYS-1:0] long_press
);

   logic [NUM_KEYS-1:0] keyNorm;

   // Normalise polarity so every channel sees 1 = pressed.
   assign keyNorm = (ACTIVE_HIGH != 0) ? key_in : ~key_in;

   // One fully independent channel per key.
   for (genvar i = 0; i < NUM_KEYS; i++) begin : gChan
      key_channel #(
         .DEBOUNCE_CYC (DEBOUNCE_CYC),
         .LONG_CYC     (LONG_CYC),
         .REPEAT_CYC   (REPEAT_CYC)
      ) uChan (
         .clk       (clk),
         .reset     (reset),
         .key_i     (keyNorm[i]),
         .pressed_o (pressed[i]),
         .short_o   (short_press[i]),
         .long_o    (long_press[i])
      );
   end

endmodule

// File: tb/tb_multi_key_press_detector.sv
// ---------------------------------------------------------------------------
// tb_multi_key_press_detector
// Drives the detector with directed and random key waveforms and compares
// every cycle against a run-length reference model of the key rules.
// ---------------------------------------------------------------------------
module tb_multi_key_press_detector;

   localparam int NK    = 2;
   localparam int DEB   = 4;
   localparam int LONGC = 20;
   localparam int REP   = 8;

   logic          clk = 1'b0;
   logic          reset;
   logic [NK-1:0] key_in;
   logic [NK-1:0] pressed;
   logic [NK-1:0] short_press;
   logic [NK-1:0] long_press;

   int total = 0;
   int bad   = 0;

   multi_key_press_detector #(
      .NUM_KEYS     (NK),
      .DEBOUNCE_CYC (DEB),
      .LONG_CYC     (LONGC),
      .REPEAT_CYC   (REP),
      .ACTIVE_HIGH  (1)
   ) dut (
      .clk         (clk),
      .reset       (reset),
      .key_in      (key_in),
      .pressed     (pressed),
      .short_press (short_press),
      .long_press  (long_press)
   );

   always #5 clk = ~clk;

   // Reference model: works on the synchronised sample stream and the length
   // of the current run of equal samples.
   logic          mP1[NK], mP2[NK], mPrev[NK], mRunVal[NK];
   int            mRun[NK], mHigh[NK];
   bit            mLocked[NK], mDown[NK], mLongDone[NK];
`ifdef KEY_REPEAT_EN
   int            mRep[NK];
`endif
   logic [NK-1:0] expP, expS, expL;

   task automatic modelReset();
      for (int k = 0; k < NK; k++) begin
         mP1[k] = 1'b0; mP2[k] = 1'b0; mPrev[k] = 1'b0; mRunVal[k] = 1'b0;
         mRun[k] = 0; mHigh[k] = 0;
         mLocked[k] = 1'b1; mDown[k] = 1'b0; mLongDone[k] = 1'b0;
`ifdef KEY_REPEAT_EN
         mRep[k] = 0;
`endif
      end
      expP = '0; expS = '0; expL = '0;
   endtask

   task automatic modelStep();
      logic s;
      for (int k = 0; k < NK; k++) begin
         s = mP2[k];
         if (s == mRunVal[k]) mRun[k]++;
         else begin mRunVal[k] = s; mRun[k] = 1; end
         expS[k] = 1'b0;
         expL[k] = 1'b0;
         if (mLocked[k]) begin
            if (!s && mRun[k] == DEB) mLocked[k] = 1'b0;
         end else if (!mDown[k]) begin
            if (s && mRun[k] == DEB + 1) begin
               mDown[k] = 1'b1; mLongDone[k] = 1'b0; mHigh[k] = 0;
            end
         end else if (!s) begin
`ifdef KEY_REPEAT_EN
            mRep[k] = 0;
`endif
            if (mRun[k] == DEB + 1) begin
               mDown[k] = 1'b0;
               expS[k]  = !mLongDone[k];
            end
         end else if (mPrev[k]) begin
            if (!mLongDone[k]) begin
               mHigh[k]++;
               if (mHigh[k] == LONGC) begin
                  mLongDone[k] = 1'b1;
                  expL[k]      = 1'b1;
`ifdef KEY_REPEAT_EN
                  mRep[k]      = 0;
`endif
               end
            end
`ifdef KEY_REPEAT_EN
            else begin
               mRep[k]++;
               if (mRep[k] == REP) begin expL[k] = 1'b1; mRep[k] = 0; end
            end
`endif
         end
         mPrev[k] = s;
         mP2[k]   = mP1[k];
         mP1[k]   = key_in[k];
         expP[k]  = mDown[k];
      end
   endtask

   // One clock: model consumes the pins seen at the edge, then settle.
   task automatic advance();
      @(posedge clk);
      modelStep();
      #1;
   endtask

   task automatic test_reset();
      logic [3*NK-1:0] got, want;
      reset  = 1'b1;
      key_in = '0;
      repeat (3) @(posedge clk);
      #1;
      modelReset();
      total++;
      if ({pressed, short_press, long_press} !== '0) begin
         bad++;
         $display("[TB] FAIL reset_outputs got=%b want=0", {pressed, short_press, long_press});
      end
      reset = 1'b0;
      for (int c = 0; c < 10; c++) begin
         advance();
         got = {pressed, short_press, long_press}; want = {expP, expS, expL};
         total++;
         if (got !== want) begin bad++; $display("[TB] FAIL reset_idle c=%0d got=%b want=%b", c, got, want); end
      end
   endtask

   task automatic test_short();
      logic [3*NK-1:0] got, want;
      int riseAt = -1, shorts = 0, longs = 0;
      for (int c = 0; c < 25; c++) begin
         key_in = {1'b0, (c < 10)};
         advance();
         got = {pressed, short_press, long_press}; want = {expP, expS, expL};
         total++;
         if (got !== want) begin bad++; $display("[TB] FAIL short_cyc c=%0d got=%b want=%b", c, got, want); end
         if (pressed[0] && riseAt < 0) riseAt = c;
         shorts += int'(short_press[0]);
         longs  += int'(long_press[0]);
      end
      total++;
      if (riseAt != DEB + 2) begin bad++; $display("[TB] FAIL short_rise got=%0d want=%0d", riseAt, DEB + 2); end
      total++;
      if (shorts != 1 || longs != 0) begin bad++; $display("[TB] FAIL short_count got=%0d/%0d want=1/0", shorts, longs); end
   endtask

   task automatic test_long();
      logic [3*NK-1:0] got, want;
      int riseAt = -1, longAt = -1, shorts = 0, longs = 0;
      for (int c = 0; c < 55; c++) begin
         key_in = {1'b0, (c < 40)};
         advance();
         got = {pressed, short_press, long_press}; want = {expP, expS, expL};
         total++;
         if (got !== want) begin bad++; $display("[TB] FAIL long_cyc c=%0d got=%b want=%b", c, got, want); end
         if (pressed[0] && riseAt < 0) riseAt = c;
         if (long_press[0] && longAt < 0) longAt = c;
         shorts += int'(short_press[0]);
         longs  += int'(long_press[0]);
      end
      total++;
      if (riseAt < 0 || longAt - riseAt != LONGC) begin
         bad++; $display("[TB] FAIL long_delay got=%0d want=%0d", longAt - riseAt, LONGC);
      end
      total++;
      if (shorts != 0 || longs != 1) begin bad++; $display("[TB] FAIL long_count got=%0d/%0d want=0/1", shorts, longs); end
   endtask

   task automatic test_glitch();
      logic [3*NK-1:0] got, want;
      int pressSeen = 0, falls = 0, riseAt = -1, longAt = -1, shorts = 0, longs = 0;
      logic lastP;
      for (int c = 0; c < 13; c++) begin
         key_in = {1'b0, (c < 3)};
         advance();
         got = {pressed, short_press, long_press}; want = {expP, expS, expL};
         total++;
         if (got !== want) begin bad++; $display("[TB] FAIL glitch_cyc c=%0d got=%b want=%b", c, got, want); end
         pressSeen += int'(pressed[0] | short_press[0] | long_press[0]);
      end
      total++;
      if (pressSeen != 0) begin bad++; $display("[TB] FAIL glitch_reject got=%0d want=0", pressSeen); end
      lastP = pressed[0];
      for (int j = 0; j < 45; j++) begin
         key_in = {1'b0, (j < 35) && (j != 15) && (j != 16)};
         advance();
         got = {pressed, short_press, long_press}; want = {expP, expS, expL};
         total++;
         if (got !== want) begin bad++; $display("[TB] FAIL dip_cyc j=%0d got=%b want=%b", j, got, want); end
         if (lastP && !pressed[0]) falls++;
         lastP = pressed[0];
         if (pressed[0] && riseAt < 0) riseAt = j;
         if (long_press[0] && longAt < 0) longAt = j;
         shorts += int'(short_press[0]);
         longs  += int'(long_press[0]);
      end
      total++;
      if (falls != 1 || shorts != 0 || longs != 1) begin
         bad++; $display("[TB] FAIL dip_events got=%0d/%0d/%0d want=1/0/1", falls, shorts, longs);
      end
      total++;
      if (riseAt < 0 || longAt - riseAt != LONGC + 3) begin
         bad++; $display("[TB] FAIL dip_hold got=%0d want=%0d", longAt - riseAt, LONGC + 3);
      end
   endtask

   task automatic test_lockout();
      logic [3*NK-1:0] got, want;
      int early = 0, later = 0;
      key_in = 2'b01;
      reset  = 1'b1;
      repeat (3) @(posedge clk);
      #1;
      modelReset();
      reset = 1'b0;
      for (int c = 0; c < 30; c++) begin
         key_in = {1'b0, !(c >= 12 && c < 18)};
         advance();
         got = {pressed, short_press, long_press}; want = {expP, expS, expL};
         total++;
         if (got !== want) begin bad++; $display("[TB] FAIL lock_cyc c=%0d got=%b want=%b", c, got, want); end
         if (c < 14) early += int'(pressed[0] | short_press[0] | long_press[0]);
         else later += int'(pressed[0]);
      end
      total++;
      if (early != 0 || later == 0) begin bad++; $display("[TB] FAIL lock_behaviour got=%0d/%0d want=0/>0", early, later); end
      key_in = '0;
      for (int c = 0; c < 8; c++) advance();
   endtask

   task automatic test_parallel();
      logic [3*NK-1:0] got, want;
      int s0 = 0, l0 = 0, s1 = 0, l1 = 0;
      for (int c = 0; c < 55; c++) begin
         key_in = {(c < 40), (c < 10)};
         advance();
         got = {pressed, short_press, long_press}; want = {expP, expS, expL};
         total++;
         if (got !== want) begin bad++; $display("[TB] FAIL par_cyc c=%0d got=%b want=%b", c, got, want); end
         s0 += int'(short_press[0]); l0 += int'(long_press[0]);
         s1 += int'(short_press[1]); l1 += int'(long_press[1]);
      end
      total++;
      if (s0 != 1 || l0 != 0 || s1 != 0 || l1 != 1) begin
         bad++; $display("[TB] FAIL par_count got=%0d/%0d/%0d/%0d want=1/0/0/1", s0, l0, s1, l1);
      end
   endtask

   task automatic test_reset_mid();
      logic [3*NK-1:0] got, want;
      int pulses = 0;
      for (int c = 0; c < 14; c++) begin
         key_in = {1'b1, (c < 10)};
         advance();
         got = {pressed, short_press, long_press}; want = {expP, expS, expL};
         total++;
         if (got !== want) begin bad++; $display("[TB] FAIL mid_cyc c=%0d got=%b want=%b", c, got, want); end
      end
      reset = 1'b1;
      #1;
      total++;
      if ({pressed, short_press, long_press} !== '0) begin
         bad++; $display("[TB] FAIL mid_async got=%b want=0", {pressed, short_press, long_press});
      end
      repeat (2) @(posedge clk);
      #1;
      modelReset();
      key_in = '0;
      reset  = 1'b0;
      for (int c = 0; c < 12; c++) begin
         advance();
         got = {pressed, short_press, long_press}; want = {expP, expS, expL};
         total++;
         if (got !== want) begin bad++; $display("[TB] FAIL mid_after c=%0d got=%b want=%b", c, got, want); end
         pulses += int'(|short_press) + int'(|long_press);
      end
      total++;
      if (pulses != 0) begin bad++; $display("[TB] FAIL mid_discard got=%0d want=0", pulses); end
   endtask

   task automatic test_random();
      logic [3*NK-1:0] got, want;
      int   remain[NK];
      logic lvl[NK];
      for (int k = 0; k < NK; k++) begin remain[k] = 0; lvl[k] = key_in[k]; end
      for (int c = 0; c < 3000; c++) begin
         for (int k = 0; k < NK; k++) begin
            if (remain[k] == 0) begin
               lvl[k] = !lvl[k];
               if ($urandom_range(0, 3) == 0) remain[k] = int'($urandom_range(1, 5));
               else remain[k] = int'($urandom_range(4, 45));
            end
            remain[k]--;
            key_in[k] = lvl[k];
         end
         advance();
         got = {pressed, short_press, long_press}; want = {expP, expS, expL};
         total++;
         if (got !== want) begin bad++; $display("[TB] FAIL rand_cyc c=%0d got=%b want=%b", c, got, want); end
      end
      key_in = '0;
      for (int c = 0; c < 10; c++) advance();
   endtask

`ifdef KEY_REPEAT_EN
   task automatic test_repeat();
      logic [3*NK-1:0] got, want;
      int riseAt = -1, firstL = -1, secondL = -1;
      for (int c = 0; c < 60; c++) begin
         key_in = {1'b0, (c < 50)};
         advance();
         got = {pressed, short_press, long_press}; want = {expP, expS, expL};
         total++;
         if (got !== want) begin bad++; $display("[TB] FAIL rep_cyc c=%0d got=%b want=%b", c, got, want); end
         if (pressed[0] && riseAt < 0) riseAt = c;
         if (long_press[0]) begin
            if (firstL < 0) firstL = c;
            else if (secondL < 0) secondL = c;
         end
      end
      total++;
      if (firstL - riseAt != LONGC || secondL - firstL != REP) begin
         bad++; $display("[TB] FAIL rep_spacing got=%0d/%0d want=%0d/%0d", firstL - riseAt, secondL - firstL, LONGC, REP);
      end
   endtask
`endif

   initial begin
      reset  = 1'b1;
      key_in = '0;
      modelReset();
      test_reset();
      test_short();
      test_long();
      test_glitch();
      test_lockout();
      test_parallel();
      test_reset_mid();
`ifdef KEY_REPEAT_EN
      test_repeat();
`endif
      test_random();
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
